// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter.
// Two writeback requesters (A: main pipeline, B: long-latency unit) each own a
// one-entry holding buffer. A bounded-starvation priority picks which buffer
// drains into the registered write_id/write_input pair feeding the regfile.
// pend_mask flags every register that still has a write in flight.
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_id,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_id,
    input  logic [31:0] b_data,
    output logic [4:0]  write_id,
    output logic [31:0] write_input,
    output logic [31:0] pend_mask
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic        bufa_full_r;
    logic [4:0]  bufa_id_r;
    logic [31:0] bufa_data_r;
    logic        bufb_full_r;
    logic [4:0]  bufb_id_r;
    logic [31:0] bufb_data_r;
    logic [3:0]  wait_r;

    logic        grant_a_s;
    logic        grant_b_s;
    logic        a_drop_s;
    logic        b_drop_s;
    logic        a_take_s;
    logic        b_take_s;
    logic [31:0] mask_s;

    // Grant selection among full buffers; B wins only once it has starved long enough.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        case ({bufa_full_r, bufb_full_r})
            2'b10: grant_a_s = 1'b1;
            2'b01: grant_b_s = 1'b1;
            2'b11: begin
                if (wait_r >= MAX_WAIT_C) begin
                    grant_b_s = 1'b1;
                end else begin
                    grant_a_s = 1'b1;
                end
            end
            default: begin
                grant_a_s = 1'b0;
                grant_b_s = 1'b0;
            end
        endcase
    end

    // Handshake: writes to r0 are swallowed; a draining slot can refill the same cycle.
    always_comb begin
        a_drop_s = (a_id == 5'd0);
        b_drop_s = (b_id == 5'd0);
        if (rst_n) begin
            a_ready = a_drop_s || !bufa_full_r || grant_a_s;
            b_ready = b_drop_s || !bufb_full_r || grant_b_s;
        end else begin
            a_ready = 1'b0;
            b_ready = 1'b0;
        end
        a_take_s = a_valid && a_ready && !a_drop_s;
        b_take_s = b_valid && b_ready && !b_drop_s;
    end

    // Holding buffer A: load on accepted offer, empty on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bufa_full_r <= 1'b0;
            bufa_id_r   <= 5'd0;
            bufa_data_r <= 32'd0;
        end else if (a_take_s) begin
            bufa_full_r <= 1'b1;
            bufa_id_r   <= a_id;
            bufa_data_r <= a_data;
        end else if (grant_a_s) begin
            bufa_full_r <= 1'b0;
        end else begin
            bufa_full_r <= bufa_full_r;
        end
    end

    // Holding buffer B: load on accepted offer, empty on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bufb_full_r <= 1'b0;
            bufb_id_r   <= 5'd0;
            bufb_data_r <= 32'd0;
        end else if (b_take_s) begin
            bufb_full_r <= 1'b1;
            bufb_id_r   <= b_id;
            bufb_data_r <= b_data;
        end else if (grant_b_s) begin
            bufb_full_r <= 1'b0;
        end else begin
            bufb_full_r <= bufb_full_r;
        end
    end

    // Starvation counter: counts cycles B sits full but ungranted, saturating at 15.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_r <= 4'd0;
        end else if (bufb_full_r && !grant_b_s) begin
            if (wait_r != 4'd15) begin
                wait_r <= wait_r + 4'd1;
            end else begin
                wait_r <= wait_r;
            end
        end else begin
            wait_r <= 4'd0;
        end
    end

    // Output register: present the granted entry; idle cycles emit id 0 and keep data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_id    <= 5'd0;
            write_input <= 32'd0;
        end else if (grant_a_s) begin
            write_id    <= bufa_id_r;
            write_input <= bufa_data_r;
        end else if (grant_b_s) begin
            write_id    <= bufb_id_r;
            write_input <= bufb_data_r;
        end else begin
            write_id    <= 5'd0;
            write_input <= write_input;
        end
    end

    // Pending-write mask from buffered entries and the output register; r0 never pends.
    always_comb begin
        mask_s = 32'd0;
        if (bufa_full_r) begin
            mask_s[bufa_id_r] = 1'b1;
        end else begin
            mask_s = mask_s;
        end
        if (bufb_full_r) begin
            mask_s[bufb_id_r] = 1'b1;
        end else begin
            mask_s = mask_s;
        end
        mask_s[write_id] = 1'b1;
        mask_s[0]        = 1'b0;
        pend_mask        = mask_s;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a write scoreboard.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_id;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_id;
    logic [31:0] b_data;
    logic [4:0]  write_id;
    logic [31:0] write_input;
    logic [31:0] pend_mask;

    typedef struct {
        logic [4:0]  id;
        logic [31:0] data;
    } wr_t;

    wr_t qa[$];
    wr_t qb[$];
    int  total = 0;
    int  bad   = 0;

    regfile_wb_arbiter #(.MAX_WAIT(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_id       (a_id),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_id       (b_id),
        .b_data     (b_data),
        .write_id   (write_id),
        .write_input(write_input),
        .pend_mask  (pend_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Pop the scoreboard whenever the DUT presents a write.
    task automatic score();
        wr_t e;
        if (write_id !== 5'd0) begin
            if (qb.size() > 0 && write_id === qb[0].id) begin
                e = qb.pop_front();
                chk("sb_b_data", write_input, e.data);
            end else if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("sb_a_id", {27'd0, write_id}, {27'd0, e.id});
                chk("sb_a_data", write_input, e.data);
            end else begin
                chk("sb_unexpected_write", {27'd0, write_id}, 32'd0);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        score();
    endtask

    task automatic push_a(input logic [4:0] id, input logic [31:0] d);
        wr_t e;
        e.id = id;
        e.data = d;
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [4:0] id, input logic [31:0] d);
        wr_t e;
        e.id = id;
        e.data = d;
        qb.push_back(e);
    endtask

    initial begin
        int stall_cnt;
        int nine_cnt;
        int nine_at;
        int ai;
        logic [31:0] exp_mask;

        // ---- reset with an A offer held ----
        rst_n   = 1'b0;
        a_valid = 1'b1;
        a_id    = 5'd5;
        a_data  = 32'h11;
        b_valid = 1'b0;
        b_id    = 5'd0;
        b_data  = 32'd0;
        #3;
        chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
        chk("rst_write_id", {27'd0, write_id}, 32'd0);
        chk("rst_pend", pend_mask, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_write_id", {27'd0, write_id}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_a_ready", {31'd0, a_ready}, 32'd1);
        push_a(5'd5, 32'h11);
        tick();
        a_valid = 1'b0;
        chk("first_pend", pend_mask, 32'h20);
        chk("first_lat_id", {27'd0, write_id}, 32'd0);
        tick();
        chk("first_write_id", {27'd0, write_id}, 32'd5);
        tick();
        chk("first_idle_id", {27'd0, write_id}, 32'd0);

        // ---- A streams ids 1,2,3, B idle ----
        for (int i = 1; i <= 3; i++) begin
            a_valid = 1'b1;
            a_id    = 5'(i);
            a_data  = 32'hA000_0000 + 32'(i);
            #1;
            chk("stream_a_ready", {31'd0, a_ready}, 32'd1);
            push_a(a_id, a_data);
            tick();
            exp_mask = (32'd1 << i) | ((i > 1) ? (32'd1 << (i - 1)) : 32'd0);
            chk("stream_pend", pend_mask, exp_mask);
            chk("stream_write_id", {27'd0, write_id}, (i > 1) ? 32'(i - 1) : 32'd0);
        end
        a_valid = 1'b0;
        tick();
        chk("stream_last_id", {27'd0, write_id}, 32'd3);
        chk("stream_last_pend", pend_mask, 32'h8);
        tick();
        chk("stream_end_pend", pend_mask, 32'd0);

        // ---- B starvation while A streams ----
        stall_cnt = 0;
        nine_cnt  = 0;
        nine_at   = -1;
        ai        = 0;
        b_valid   = 1'b1;
        b_id      = 5'd9;
        b_data    = 32'hBEEF;
        for (int c = 0; c < 14; c++) begin
            a_valid = (ai < 8);
            a_id    = 5'(10 + ai);
            a_data  = 32'hC000_0000 + 32'(ai);
            #1;
            if (c == 0) chk("starve_b_ready0", {31'd0, b_ready}, 32'd1);
            if (a_valid) begin
                if (a_ready) begin
                    push_a(a_id, a_data);
                    ai++;
                end else begin
                    stall_cnt++;
                end
            end
            if (b_valid && b_ready) push_b(b_id, b_data);
            tick();
            b_valid = 1'b0;
            if (write_id === 5'd9) begin
                nine_cnt++;
                nine_at = c;
            end
        end
        chk("starve_nine_count", 32'(nine_cnt), 32'd1);
        chk("starve_nine_at", 32'(nine_at), 32'd4);
        chk("starve_a_stalls", 32'(stall_cnt), 32'd1);

        // ---- simultaneous offers, wait counter at 0 ----
        a_valid = 1'b1;
        a_id    = 5'd4;
        a_data  = 32'h4444;
        b_valid = 1'b1;
        b_id    = 5'd6;
        b_data  = 32'h6666;
        #1;
        chk("sim_a_ready", {31'd0, a_ready}, 32'd1);
        chk("sim_b_ready", {31'd0, b_ready}, 32'd1);
        push_a(5'd4, 32'h4444);
        push_b(5'd6, 32'h6666);
        tick();
        a_valid = 1'b0;
        b_id    = 5'd8;
        b_data  = 32'h8888;
        #1;
        chk("sim_b_blocked", {31'd0, b_ready}, 32'd0);
        tick();
        chk("sim_first_id", {27'd0, write_id}, 32'd4);
        #1;
        chk("sim_b_freed", {31'd0, b_ready}, 32'd1);
        push_b(5'd8, 32'h8888);
        tick();
        b_valid = 1'b0;
        chk("sim_second_id", {27'd0, write_id}, 32'd6);
        tick();
        chk("sim_third_id", {27'd0, write_id}, 32'd8);
        tick();

        // ---- r0 filter ----
        a_valid = 1'b1;
        a_id    = 5'd0;
        a_data  = 32'hFFFF_FFFF;
        #1;
        chk("r0_a_ready", {31'd0, a_ready}, 32'd1);
        tick();
        chk("r0_pend", pend_mask, 32'd0);
        tick();
        a_valid = 1'b0;
        chk("r0_write_id", {27'd0, write_id}, 32'd0);
        chk("r0_pend2", pend_mask, 32'd0);

        // ---- reset mid-operation ----
        a_valid = 1'b1;
        a_id    = 5'd7;
        a_data  = 32'h7777;
        push_a(5'd7, 32'h7777);
        tick();
        a_id    = 5'd12;
        a_data  = 32'hCCCC;
        b_valid = 1'b1;
        b_id    = 5'd13;
        b_data  = 32'hDDDD;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("mid_write_id", {27'd0, write_id}, 32'd7);
        chk("mid_pend", pend_mask, 32'h0000_3080);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_write_id", {27'd0, write_id}, 32'd0);
        chk("mid_rst_pend", pend_mask, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_idle", {27'd0, write_id}, 32'd0);
        end
        chk("sb_qa_empty", 32'(qa.size()), 32'd0);
        chk("sb_qb_empty", 32'(qb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
